// File: rtl/vx_div_pkg.sv
// Shared types and helpers for the iterative divider.
// State encoding and counter sizing live here.
package vx_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/vx_div_abs.sv
// Conditional two's-complement negate, modulo 2^WIDTH.
// Used for operand abs and for result sign fix-up.
module vx_div_abs
    import vx_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/vx_iter_divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
// DIV/DIVU/REM/REMU semantics with a tag carried to writeback.
module vx_iter_divider
    import vx_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED    = 0,
    parameter int TAG_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [TAG_WIDTH-1:0] tag_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Remainder stays below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic nq_q, nq_d;
    logic nr_q, nr_d;
    logic dz_q, dz_d;
    logic fin_q, fin_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_WIDTH-1:0] tago_q, tago_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic vout_q, vout_d;

    logic sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [WIDTH:0] trial, diff;

    assign sa = (SIGNED != 0) && dividend[WIDTH-1];
    assign sb = (SIGNED != 0) && divisor[WIDTH-1];

    vx_div_abs #(.WIDTH(WIDTH)) u_abs_a (.a(dividend), .neg(sa), .y(abs_a));
    vx_div_abs #(.WIDTH(WIDTH)) u_abs_b (.a(divisor), .neg(sb), .y(abs_b));
    vx_div_abs #(.WIDTH(WIDTH)) u_fix_q (.a(dvd_q), .neg(nq_q), .y(q_fix));
    vx_div_abs #(.WIDTH(WIDTH)) u_fix_r (.a(rem_q), .neg(nr_q), .y(r_fix));

    assign trial = {rem_q, dvd_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dsr_q};

    assign ready_in  = (state_q == IDLE);
    assign valid_out = vout_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign tag_out   = tago_q;

    // Next-state, iteration step and result capture.
    // A closing BUSY cycle applies sign fix-up from registered values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        orig_d  = orig_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        dz_d    = dz_q;
        fin_d   = fin_q;
        tag_d   = tag_q;
        tago_d  = tago_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        vout_d  = vout_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = BUSY;
                    dvd_d   = abs_a;
                    dsr_d   = abs_b;
                    orig_d  = dividend;
                    nq_d    = sa ^ sb;
                    nr_d    = sa;
                    dz_d    = (divisor == '0);
                    tag_d   = tag_in;
                    rem_d   = '0;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            BUSY: begin
                if (fin_q) begin
                    state_d = DONE;
                    vout_d  = 1'b1;
                    quot_d  = dz_q ? '1 : q_fix;
                    remo_d  = dz_q ? orig_q : r_fix;
                    tago_d  = tag_q;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = trial[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    fin_d = (cnt_q == LAST);
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                    vout_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                vout_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            orig_q  <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            dz_q    <= 1'b0;
            fin_q   <= 1'b0;
            tag_q   <= '0;
            tago_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            orig_q  <= orig_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            dz_q    <= dz_d;
            fin_q   <= fin_d;
            tag_q   <= tag_d;
            tago_q  <= tago_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            vout_q  <= vout_d;
        end
    end

endmodule

// File: tb/tb_vx_iter_divider.sv
// Bench for vx_iter_divider: unsigned and signed 8-bit instances.
// Arithmetic model plus directed vectors with literal results.
module tb_vx_iter_divider;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic reset_n;
    logic vin[2];
    logic rdy[2];
    logic vout[2];
    logic rout[2];
    logic [W-1:0] a_in[2];
    logic [W-1:0] b_in[2];
    logic [W-1:0] q[2];
    logic [W-1:0] r[2];
    logic t_in[2];
    logic t[2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vx_iter_divider #(.WIDTH(W), .SIGNED(0), .TAG_WIDTH(1)) u_div_u (
        .clk(clk), .reset_n(reset_n),
        .valid_in(vin[0]), .ready_in(rdy[0]),
        .dividend(a_in[0]), .divisor(b_in[0]), .tag_in(t_in[0]),
        .valid_out(vout[0]), .ready_out(rout[0]),
        .quotient(q[0]), .remainder(r[0]), .tag_out(t[0])
    );

    vx_iter_divider #(.WIDTH(W), .SIGNED(1), .TAG_WIDTH(1)) u_div_s (
        .clk(clk), .reset_n(reset_n),
        .valid_in(vin[1]), .ready_in(rdy[1]),
        .dividend(a_in[1]), .divisor(b_in[1]), .tag_in(t_in[1]),
        .valid_out(vout[1]), .ready_out(rout[1]),
        .quotient(q[1]), .remainder(r[1]), .tag_out(t[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: {quotient, remainder}.
    function automatic logic [15:0] ref_div(input int s,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        int sa, sb, qq, rr;
        if (b == 8'h00) return {8'hFF, a};
        if (s == 0) return {a / b, a % b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {qq[7:0], rr[7:0]};
    endfunction

    logic m_pend[2] = '{1'b0, 1'b0};
    int m_age[2] = '{0, 0};
    logic [7:0] m_q[2];
    logic [7:0] m_r[2];
    logic m_t[2];

    // Transaction-level model: pending op, age since accept, result.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_pend[i] <= 1'b0;
                m_age[i]  <= 0;
            end else if (vin[i] && !m_pend[i]) begin
                m_pend[i] <= 1'b1;
                m_age[i]  <= 0;
                {m_q[i], m_r[i]} <= ref_div(i, a_in[i], b_in[i]);
                m_t[i] <= t_in[i];
            end else if (m_pend[i] && m_age[i] >= LAT && rout[i]) begin
                m_pend[i] <= 1'b0;
            end else if (m_pend[i]) begin
                m_age[i] <= m_age[i] + 1;
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic ev;
            ev = m_pend[i] && (m_age[i] >= LAT);
            chk($sformatf("dut%0d.ready_in", i), rdy[i], !m_pend[i]);
            chk($sformatf("dut%0d.valid_out", i), vout[i], ev);
            if (ev) begin
                chk($sformatf("dut%0d.quotient", i), q[i], m_q[i]);
                chk($sformatf("dut%0d.remainder", i), r[i], m_r[i]);
                chk($sformatf("dut%0d.tag_out", i), t[i], m_t[i]);
            end
            if (!reset_n) begin
                chk($sformatf("dut%0d.rst_q", i), q[i], 0);
                chk($sformatf("dut%0d.rst_r", i), r[i], 0);
                chk($sformatf("dut%0d.rst_tag", i), t[i], 0);
            end
        end
    end

    task automatic wait_valid(input int s, output int n);
        n = 0;
        while (!vout[s] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic op(input int s, input logic [7:0] a,
                      input logic [7:0] b, input logic tg,
                      input logic [7:0] eq, input logic [7:0] er);
        int n;
        @(posedge clk);
        #1;
        vin[s]  = 1'b1;
        a_in[s] = a;
        b_in[s] = b;
        t_in[s] = tg;
        @(posedge clk);
        #1;
        vin[s] = 1'b0;
        chk($sformatf("op%0d %h/%h ready_low", s, a, b), rdy[s], 0);
        wait_valid(s, n);
        chk($sformatf("op%0d %h/%h latency", s, a, b), n, LAT);
        chk($sformatf("op%0d %h/%h quotient", s, a, b), q[s], eq);
        chk($sformatf("op%0d %h/%h remainder", s, a, b), r[s], er);
        chk($sformatf("op%0d %h/%h tag", s, a, b), t[s], tg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vin[i]  = 1'b0;
            rout[i] = 1'b1;
            a_in[i] = '0;
            b_in[i] = '0;
            t_in[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #3;
        chk("reset ready_in", rdy[0], 1);
        chk("reset valid_out", vout[0], 0);
        chk("reset quotient", q[1], 0);
        reset_n = 1'b1;

        op(0, 8'd200, 8'd7, 1'b1, 8'd28, 8'd4);
        op(0, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55);
        op(0, 8'h0D, 8'hFF, 1'b1, 8'h00, 8'h0D);
        op(0, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00);
        op(1, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF);
        op(1, 8'h07, 8'hFE, 1'b0, 8'hFD, 8'h01);
        op(1, 8'h80, 8'h00, 1'b1, 8'hFF, 8'h80);
        op(1, 8'h80, 8'hFF, 1'b0, 8'h80, 8'h00);
        op(1, 8'h80, 8'h7F, 1'b1, 8'hFF, 8'hFF);
        op(1, 8'h7F, 8'hFF, 1'b0, 8'h81, 8'h00);

        // Back-pressure with a competing request held on valid_in.
        @(posedge clk);
        #1;
        rout[0] = 1'b0;
        vin[0]  = 1'b1;
        a_in[0] = 8'h30;
        b_in[0] = 8'h05;
        t_in[0] = 1'b0;
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        wait_valid(0, n);
        chk("bp latency", n, LAT);
        vin[0]  = 1'b1;
        a_in[0] = 8'h10;
        b_in[0] = 8'h02;
        t_in[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp hold quotient", q[0], 8'd9);
        chk("bp hold remainder", r[0], 8'd3);
        chk("bp hold tag", t[0], 0);
        chk("bp hold ready_in", rdy[0], 0);
        chk("bp hold valid_out", vout[0], 1);
        rout[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp idle ready_in", rdy[0], 1);
        chk("bp idle valid_out", vout[0], 0);
        @(posedge clk);
        #1;
        chk("bp accept ready_in", rdy[0], 0);
        vin[0] = 1'b0;
        wait_valid(0, n);
        chk("bp2 latency", n, LAT);
        chk("bp2 quotient", q[0], 8'd8);
        chk("bp2 remainder", r[0], 8'd0);
        chk("bp2 tag", t[0], 1);

        // Reset during the third BUSY cycle.
        @(posedge clk);
        #1;
        vin[0]  = 1'b1;
        a_in[0] = 8'd200;
        b_in[0] = 8'd7;
        t_in[0] = 1'b1;
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst valid_out", vout[0], 0);
        chk("midrst ready_in", rdy[0], 1);
        chk("midrst quotient", q[0], 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        op(0, 8'd100, 8'd9, 1'b0, 8'd11, 8'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
